// File: rtl/clken_gen.sv
// Purpose : multi-channel programmable clock-enable generator; per-channel tick strobe and square wave.
// Latency : tick/clk_out are registered, so a terminal count shows up one clk after the edge that reaches it.
// Backpressure: cfg_ready = !pend[cfg_ch]; only one divisor update may be outstanding per channel.
// Ports   : clk/arst (async, active-high) | en (count enable), sync (phase restart)
//           cfg_valid/cfg_ready/cfg_ch/cfg_div (divisor update) | tick, clk_out (per-channel outputs)
module clken_gen #(
    parameter int          NCH       = 4,
    parameter int          W         = 16,
    parameter int unsigned RESET_DIV = 2,
    localparam int         CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           en,
    input  logic           sync,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_div,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] clk_out
);

    localparam logic [W-1:0] RST_DIV = W'(RESET_DIV);
    localparam logic [W-1:0] RST_CNT = (RESET_DIV == 0) ? '0 : W'(RESET_DIV - 1);

    logic [W-1:0]   div_q  [NCH];
    logic [W-1:0]   div_d  [NCH];
    logic [W-1:0]   nxt_q  [NCH];
    logic [W-1:0]   nxt_d  [NCH];
    logic [W-1:0]   cnt_q  [NCH];
    logic [W-1:0]   cnt_d  [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] tick_q;
    logic [NCH-1:0] tick_d;
    logic [NCH-1:0] clk_out_q;
    logic [NCH-1:0] clk_out_d;

    // Counter reload for a divisor d: d-1, with d=0 (disabled) parking at 0.
    function automatic logic [W-1:0] load_val(input logic [W-1:0] d);
        return (d == '0) ? '0 : d - W'(1);
    endfunction

    // Out-of-range channel numbers match nothing, so they read as ready and are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                cfg_ready = ~pend_q[i];
            end
        end
    end

    always_comb begin
        logic         hit;
        logic [W-1:0] new_div;
        hit     = 1'b0;
        new_div = '0;
        for (int i = 0; i < NCH; i++) begin
            div_d[i]     = div_q[i];
            nxt_d[i]     = nxt_q[i];
            cnt_d[i]     = cnt_q[i];
            pend_d[i]    = pend_q[i];
            tick_d[i]    = 1'b0;
            clk_out_d[i] = clk_out_q[i];

            // hit implies pend_q[i]==0, so a new write never collides with an apply below.
            hit = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));

            if (sync) begin
                // A write landing with sync is treated as already pending, so it wins.
                new_div      = hit ? cfg_div : (pend_q[i] ? nxt_q[i] : div_q[i]);
                div_d[i]     = new_div;
                cnt_d[i]     = load_val(new_div);
                pend_d[i]    = 1'b0;
                clk_out_d[i] = 1'b0;
                if (hit) begin
                    nxt_d[i] = cfg_div;
                end
            end else begin
                if (div_q[i] == '0) begin
                    // Disabled channel: outputs parked; a pending divisor applies at once.
                    clk_out_d[i] = 1'b0;
                    cnt_d[i]     = '0;
                    if (pend_q[i]) begin
                        div_d[i]  = nxt_q[i];
                        cnt_d[i]  = load_val(nxt_q[i]);
                        pend_d[i] = 1'b0;
                    end
                end else if (en) begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - W'(1);
                    end else begin
                        tick_d[i]    = 1'b1;
                        clk_out_d[i] = ~clk_out_q[i];
                        if (pend_q[i]) begin
                            div_d[i]  = nxt_q[i];
                            cnt_d[i]  = load_val(nxt_q[i]);
                            pend_d[i] = 1'b0;
                        end else begin
                            cnt_d[i] = load_val(div_q[i]);
                        end
                    end
                end
                if (hit) begin
                    nxt_d[i]  = cfg_div;
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= RST_DIV;
                nxt_q[i] <= RST_DIV;
                cnt_q[i] <= RST_CNT;
            end
            pend_q    <= '0;
            tick_q    <= '0;
            clk_out_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= div_d[i];
                nxt_q[i] <= nxt_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;

endmodule

// File: tb/tb_clken_gen.sv
module tb_clken_gen;

    logic        clk = 1'b0;
    logic        arst;
    logic        en;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [3:0]  tick;
    logic [3:0]  clk_out;

    int tests = 0;
    int fails = 0;

    clken_gen #(.NCH(4), .W(16), .RESET_DIV(2)) dut (
        .clk       (clk),
        .arst      (arst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] tk_exp [6];
        logic [3:0] ck_exp [6];
        logic [3:0] exp_t;
        logic [3:0] exp_c;
        logic       seen;

        tk_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1001};
        ck_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110};

        arst = 1'b1; en = 1'b0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 16'd0;
        step();
        step();
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);

        // Defaults (div=2): ticks on even edges, clk_out period 4.
        arst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_t = (k % 2 == 0) ? 4'hF : 4'h0;
            exp_c = ((k / 2) % 2 == 1) ? 4'hF : 4'h0;
            chk($sformatf("dflt_tick_e%0d", k), 32'(tick), 32'(exp_t));
            chk($sformatf("dflt_clk_e%0d", k), 32'(clk_out), 32'(exp_c));
        end

        // ch1 -> 5: old period runs out first, then period 5.
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
        chk("ch1_ready_before", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        chk("ch1_ready_pending", 32'(cfg_ready), 32'h0);
        chk("e9_tick", 32'(tick), 32'h0);
        step();
        chk("e10_tick", 32'(tick), 32'hF);
        chk("ch1_ready_after", 32'(cfg_ready), 32'h1);
        for (int k = 11; k <= 20; k++) begin
            step();
            exp_t = (k % 2 == 0) ? 4'b1101 : 4'b0000;
            if (k == 15 || k == 20) exp_t[1] = 1'b1;
            exp_c = ((k / 2) % 2 == 1) ? 4'b1101 : 4'b0000;
            exp_c[1] = (k >= 15 && k < 20) ? 1'b0 : 1'b1;
            chk($sformatf("p5_tick_e%0d", k), 32'(tick), 32'(exp_t));
            chk($sformatf("p5_clk_e%0d", k), 32'(clk_out), 32'(exp_c));
        end

        // With en low, writes stay pending and outputs hold.
        en = 1'b0;
        cfg_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 2'(c);
            cfg_div = 16'(3 + c);
            step();
        end
        cfg_valid = 1'b0;
        cfg_ch = 2'd0;
        step();
        step();
        chk("en0_pend_held", 32'(cfg_ready), 32'h0);
        chk("en0_tick", 32'(tick), 32'h0);
        chk("en0_clk_hold", 32'(clk_out), 32'h2);

        // sync applies 3,4,5,6 and restarts phases.
        sync = 1'b1;
        step();
        sync = 1'b0; en = 1'b1;
        chk("sync_clk", 32'(clk_out), 32'h0);
        chk("sync_tick", 32'(tick), 32'h0);
        chk("sync_ready", 32'(cfg_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("sync_tick_e%0d", k + 1), 32'(tick), 32'(tk_exp[k]));
            chk($sformatf("sync_clk_e%0d", k + 1), 32'(clk_out), 32'(ck_exp[k]));
        end

        // sync with concurrent write ch2=7.
        sync = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd7;
        step();
        sync = 1'b0; cfg_valid = 1'b0;
        chk("sync7_clk", 32'(clk_out), 32'h0);
        chk("sync7_ready", 32'(cfg_ready), 32'h1);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("sync7_t2_e%0d", k), 32'(tick[2]), 32'(k == 7));
        end
        chk("sync7_tick_e7", 32'(tick), 32'h4);

        // en toggling, ch1 div=4 -> tick period 8.
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            en = (k % 2 == 1);
            step();
            chk($sformatf("tog_t1_e%0d", k), 32'(tick[1]), 32'(k == 7 || k == 15));
            if (!en) chk($sformatf("tog_en0_e%0d", k), 32'(tick), 32'h0);
        end

        // ch0 disabled via div=0.
        en = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd0;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("dis_t0_e%0d", k), 32'(tick[0]), 32'h0);
            chk($sformatf("dis_c0_e%0d", k), 32'(clk_out[0]), 32'h0);
        end
        en = 1'b0;
        cfg_valid = 1'b1; cfg_div = 16'd3;
        step();
        cfg_valid = 1'b0;
        chk("dis_pend", 32'(cfg_ready), 32'h0);
        step();
        chk("dis_applied_en0", 32'(cfg_ready), 32'h1);
        en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("dis3_t0_e%0d", k), 32'(tick[0]), 32'(k == 3));
        end

        // Reset mid-count with a pending update on ch3.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd9;
        step();
        cfg_valid = 1'b0;
        chk("rst_pre_pend", 32'(cfg_ready), 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (tick != 4'h0) seen = 1'b1;
        end
        chk("rst_pre_active", 32'(seen), 32'h1);
        #3 arst = 1'b1;
        #1;
        chk("arst_tick", 32'(tick), 32'h0);
        chk("arst_clk", 32'(clk_out), 32'h0);
        chk("arst_pend_gone", 32'(cfg_ready), 32'h1);
        arst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_t = (k % 2 == 0) ? 4'hF : 4'h0;
            exp_c = ((k / 2) % 2 == 1) ? 4'hF : 4'h0;
            chk($sformatf("post_rst_tick_e%0d", k), 32'(tick), 32'(exp_t));
            chk($sformatf("post_rst_clk_e%0d", k), 32'(clk_out), 32'(exp_c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
